alu_issue_ctrl: RTL and testbench

Multi-cycle control unit that drives the ALU. It fetches 64-bit instruction words, reads operands from a 16×64 register file, and presents them to the ALU's operand, opcode, immediate and flag inputs. It then consumes the ALU result (C, F3, addrch, naddr) to perform write-back, flag update, PC redirect, or a data-memory store. It sits between instruction memory, data memory and the ALU as the issue/retire end of the ALU interface.

---
 rtl/alu_pkg.sv | 86 ++++++++
 rtl/alu_regfile.sv | 34 +++
 rtl/alu_issue_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, instruction field positions and FSM state type
// for the ALU issue/retire controller.
package alu_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 16;
  localparam int RIDX_W = 4;
  localparam int OP_W   = 6;

  localparam logic [3:0] R8 = 4'd8;

  localparam logic [OP_W-1:0] OP_ADD  = 6'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 6'd1;
  localparam logic [OP_W-1:0] OP_SHL  = 6'd2;
  localparam logic [OP_W-1:0] OP_SHR  = 6'd3;
  localparam logic [OP_W-1:0] OP_MOV  = 6'd4;
  localparam logic [OP_W-1:0] OP_LDI  = 6'd5;
  localparam logic [OP_W-1:0] OP_ST6  = 6'd6;
  localparam logic [OP_W-1:0] OP_ST7  = 6'd7;
  localparam logic [OP_W-1:0] OP_EQ   = 6'd8;
  localparam logic [OP_W-1:0] OP_NE   = 6'd9;
  localparam logic [OP_W-1:0] OP_LT   = 6'd10;
  localparam logic [OP_W-1:0] OP_GT   = 6'd11;
  localparam logic [OP_W-1:0] OP_AND  = 6'd12;
  localparam logic [OP_W-1:0] OP_NAND = 6'd13;
  localparam logic [OP_W-1:0] OP_JMP  = 6'd14;
  localparam logic [OP_W-1:0] OP_JF   = 6'd15;
  localparam logic [OP_W-1:0] OP_MUL  = 6'd16;
  localparam logic [OP_W-1:0] OP_DIV  = 6'd17;
  localparam logic [OP_W-1:0] OP_HALT = 6'd63;

  localparam int F_OP_HI  = 63;
  localparam int F_OP_LO  = 58;
  localparam int F_RD_HI  = 57;
  localparam int F_RD_LO  = 54;
  localparam int F_RS_HI  = 53;
  localparam int F_RS_LO  = 50;
  localparam int F_HL     = 49;
  localparam int F_IMM_HI = 31;
  localparam int F_IMM_LO = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_STORE,
    S_HALT
  } state_t;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs;
    logic              hl;
    logic [31:0]       imm;
  } instr_t;

  function automatic logic is_wr(
    input logic [OP_W-1:0] op
  );
    return op inside {OP_ADD, OP_SUB, OP_SHL,
                      OP_SHR, OP_MOV, OP_LDI,
                      OP_MUL};
  endfunction

  function automatic logic is_flag(
    input logic [OP_W-1:0] op
  );
    return op inside {OP_EQ, OP_NE, OP_LT,
                      OP_GT, OP_AND, OP_NAND};
  endfunction

  function automatic logic is_jmp(
    input logic [OP_W-1:0] op
  );
    return op inside {OP_JMP, OP_JF};
  endfunction

  function automatic logic is_store(
    input logic [OP_W-1:0] op
  );
    return op inside {OP_ST6, OP_ST7};
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 16x64 register file: three async read ports (rd, rs, fixed R8)
// and one synchronous write port.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [RIDX_W-1:0] ra_a,
  input  logic [RIDX_W-1:0] ra_b,
  output logic [XLEN-1:0]   rd_a,
  output logic [XLEN-1:0]   rd_b,
  output logic [XLEN-1:0]   rd_8,
  input  logic              we,
  input  logic [RIDX_W-1:0] wa,
  input  logic [XLEN-1:0]   wd
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rd_a = mem[ra_a];
  assign rd_b = mem[ra_b];
  assign rd_8 = mem[R8];

endmodule

// File: rtl/alu_issue_ctrl.sv
// Non-pipelined issue/retire controller for the external ALU:
// fetch, decode/operand read, execute capture, write-back or store.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [XLEN-1:0]   imem_data,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [XLEN-1:0]   alu_reg8,
  output logic [31:0]       alu_value,
  output logic              alu_highlow,
  output logic              alu_f1,
  output logic              alu_f2,
  output logic [OP_W-1:0]   alu_instr,
  input  logic [XLEN-1:0]   alu_c,
  input  logic              alu_f3,
  input  logic              alu_addrch,
  input  logic [XLEN-1:0]   alu_naddr,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  input  logic              dmem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              err
);

  state_t st, st_d;

  logic              req_q, we_q;
  instr_t            ir;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              f1, f2, f1_d, f2_d;
  logic              err_q, err_d;
  logic [XLEN-1:0]   c_q;
  logic              f3_q, ach_q;
  logic [ADDR_W-1:0] na_q;

  logic ir_ld, dec_ld, ex_ld;

  logic              rf_we;
  logic [XLEN-1:0]   rf_wd;
  logic [XLEN-1:0]   rv_a, rv_b, rv_8;

  logic unused_bits;
  assign unused_bits = ^{imem_data[48:32],
                         alu_naddr[XLEN-1:ADDR_W]};

  alu_regfile u_rf (
    .clock (clock),
    .reset (reset),
    .ra_a  (ir.rd),
    .ra_b  (ir.rs),
    .rd_a  (rv_a),
    .rd_b  (rv_b),
    .rd_8  (rv_8),
    .we    (rf_we),
    .wa    (ir.rd),
    .wd    (rf_wd)
  );

  always_comb begin
    st_d   = st;
    pc_d   = pc_q;
    f1_d   = f1;
    f2_d   = f2;
    err_d  = err_q;
    rf_we  = 1'b0;
    rf_wd  = c_q;
    ir_ld  = 1'b0;
    dec_ld = 1'b0;
    ex_ld  = 1'b0;
    unique case (st)
      S_FETCH: begin
        if (req_q && imem_ack) begin
          ir_ld = 1'b1;
          st_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        dec_ld = 1'b1;
        st_d   = (ir.op == OP_HALT) ? S_HALT
                                    : S_EXEC;
      end
      S_EXEC: begin
        ex_ld = 1'b1;
        st_d  = is_store(ir.op) ? S_STORE : S_WB;
      end
      S_WB: begin
        st_d = S_FETCH;
        pc_d = pc_q + ADDR_W'(1);
        unique case (1'b1)
          is_wr(ir.op): rf_we = 1'b1;
          (ir.op == OP_DIV): begin
            rf_we = 1'b1;
            // divide by zero retires as 0
            if (alu_b == '0) begin
              rf_wd = '0;
              err_d = 1'b1;
            end
          end
          is_flag(ir.op): begin
            f2_d = f1;
            f1_d = f3_q;
          end
          is_jmp(ir.op): begin
            if (ach_q) pc_d = na_q;
          end
          default: ;
        endcase
      end
      S_STORE: begin
        if (we_q && dmem_ack) begin
          pc_d = pc_q + ADDR_W'(1);
          st_d = S_FETCH;
        end
      end
      S_HALT: ;
      default: st_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      st    <= S_FETCH;
      req_q <= 1'b0;
      we_q  <= 1'b0;
      pc_q  <= '0;
      f1    <= 1'b0;
      f2    <= 1'b0;
      err_q <= 1'b0;
      ir    <= '0;
      c_q   <= '0;
      f3_q  <= 1'b0;
      ach_q <= 1'b0;
      na_q  <= '0;
    end else begin
      st    <= st_d;
      req_q <= (st_d == S_FETCH);
      we_q  <= (st_d == S_STORE);
      pc_q  <= pc_d;
      f1    <= f1_d;
      f2    <= f2_d;
      err_q <= err_d;
      if (ir_ld) begin
        ir.op  <= imem_data[F_OP_HI:F_OP_LO];
        ir.rd  <= imem_data[F_RD_HI:F_RD_LO];
        ir.rs  <= imem_data[F_RS_HI:F_RS_LO];
        ir.hl  <= imem_data[F_HL];
        ir.imm <= imem_data[F_IMM_HI:F_IMM_LO];
      end
      if (ex_ld) begin
        c_q   <= alu_c;
        f3_q  <= alu_f3;
        ach_q <= alu_addrch;
        na_q  <= alu_naddr[ADDR_W-1:0];
      end
    end
  end

  // operands stay frozen from DECODE until the next DECODE
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_reg8    <= '0;
      alu_value   <= '0;
      alu_highlow <= 1'b0;
      alu_f1      <= 1'b0;
      alu_f2      <= 1'b0;
      alu_instr   <= '0;
    end else if (dec_ld) begin
      alu_a       <= rv_a;
      alu_b       <= rv_b;
      alu_reg8    <= rv_8;
      alu_value   <= ir.imm;
      alu_highlow <= ir.hl;
      alu_f1      <= f1;
      alu_f2      <= f2;
      alu_instr   <= ir.op;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = na_q;
  assign dmem_wdata = c_q;
  assign pc         = pc_q;
  assign halted     = (st == S_HALT);
  assign err        = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl; the bench plays the ALU and
// both memories with hand-computed responses.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int AW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack = 1'b0;
  logic [63:0]   imem_data = '0;
  logic [63:0]   alu_a, alu_b, alu_reg8;
  logic [31:0]   alu_value;
  logic          alu_highlow, alu_f1, alu_f2;
  logic [5:0]    alu_instr;
  logic [63:0]   alu_c = '0;
  logic          alu_f3 = 1'b0;
  logic          alu_addrch = 1'b0;
  logic [63:0]   alu_naddr = '0;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [63:0]   dmem_wdata;
  logic          dmem_ack = 1'b0;
  logic [AW-1:0] pc;
  logic          halted, err;

  int ncmp = 0;
  int nerr = 0;

  alu_issue_ctrl #(.ADDR_W(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_reg8    (alu_reg8),
    .alu_value   (alu_value),
    .alu_highlow (alu_highlow),
    .alu_f1      (alu_f1),
    .alu_f2      (alu_f2),
    .alu_instr   (alu_instr),
    .alu_c       (alu_c),
    .alu_f3      (alu_f3),
    .alu_addrch  (alu_addrch),
    .alu_naddr   (alu_naddr),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_ack    (dmem_ack),
    .pc          (pc),
    .halted      (halted),
    .err         (err)
  );

  always #5 clock = ~clock;

  function automatic logic [63:0] enc(
    input logic [5:0]  op,
    input logic [3:0]  rd,
    input logic [3:0]  rs,
    input logic        hl,
    input logic [31:0] imm
  );
    return {op, rd, rs, hl, 17'd0, imm};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("req_wait", 64'(imem_req), 64'd1);
  endtask

  task automatic issue(
    input  logic [63:0] w,
    input  logic [63:0] c,
    input  logic        f3,
    input  logic        ach,
    input  logic [63:0] na,
    output int          n
  );
    wait_req();
    imem_data  = w;
    imem_ack   = 1'b1;
    alu_c      = c;
    alu_f3     = f3;
    alu_addrch = ach;
    alu_naddr  = na;
    @(negedge clock);
    imem_ack  = 1'b0;
    imem_data = '0;
    n = 1;
    while (!imem_req && !dmem_we && !halted && n < 50) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hreq;

    repeat (2) @(negedge clock);
    chk("rst_req", 64'(imem_req), 0);
    chk("rst_pc", 64'(pc), 0);
    chk("rst_halted", 64'(halted), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_we", 64'(dmem_we), 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_instr", 64'(alu_instr), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("req_after_rst", 64'(imem_req), 1);
    chk("imem_addr0", 64'(imem_addr), 0);

    issue(enc(OP_LDI, 0, 0, 0, 5), 64'h5, 0, 0, 0, n);
    chk("ldi_cyc", 64'(n), 4);
    chk("ldi_pc", 64'(pc), 1);
    chk("ldi_instr", 64'(alu_instr), 5);
    chk("ldi_value", 64'(alu_value), 5);
    chk("ldi_hl", 64'(alu_highlow), 0);
    chk("ldi_a", alu_a, 0);

    issue(enc(OP_ADD, 1, 0, 0, 0), 64'hA, 0, 0, 0, n);
    chk("add_cyc", 64'(n), 4);
    chk("add_pc", 64'(pc), 2);
    chk("add_b_r0", alu_b, 5);

    issue(enc(OP_MOV, 2, 1, 0, 7), 64'h7, 0, 0, 0, n);
    chk("mov_b_r1", alu_b, 64'hA);
    chk("mov_pc", 64'(pc), 3);

    issue(enc(OP_LDI, 3, 0, 1, 7), 64'h7, 0, 0, 0, n);
    chk("ldi_hl1", 64'(alu_highlow), 1);

    issue(enc(OP_MOV, 8, 0, 0, 32'h40), 64'h40, 0, 0, 0, n);
    chk("mov8_pc", 64'(pc), 5);

    issue(enc(OP_EQ, 2, 3, 0, 0), 0, 1, 0, 0, n);
    chk("eq_a", alu_a, 7);
    chk("eq_b", alu_b, 7);
    chk("eq_r8", alu_reg8, 64'h40);
    chk("eq_f1", 64'(alu_f1), 0);
    chk("eq_pc", 64'(pc), 6);

    issue(enc(OP_EQ, 2, 3, 0, 0), 0, 1, 0, 0, n);
    chk("eq2_f1", 64'(alu_f1), 1);
    chk("eq2_f2", 64'(alu_f2), 0);

    issue(enc(OP_JF, 0, 0, 0, 0), 0, 0, 1, 64'h40, n);
    chk("jf_f1", 64'(alu_f1), 1);
    chk("jf_f2", 64'(alu_f2), 1);
    chk("jf_cyc", 64'(n), 4);
    chk("jf_pc", 64'(pc), 64'h40);

    issue(enc(OP_EQ, 2, 0, 0, 0), 0, 0, 0, 0, n);
    chk("eq3_pc", 64'(pc), 64'h41);

    issue(enc(OP_JF, 0, 0, 0, 0), 0, 0, 0, 64'h40, n);
    chk("jf0_f1", 64'(alu_f1), 0);
    chk("jf0_f2", 64'(alu_f2), 1);
    chk("jf0_pc", 64'(pc), 64'h42);

    issue(enc(OP_ST6, 1, 8, 0, 0), 64'hA, 0, 0, 64'h40, n);
    chk("st_cyc", 64'(n), 3);
    chk("st_we1", 64'(dmem_we), 1);
    chk("st_addr", 64'(dmem_addr), 64'h40);
    chk("st_data", dmem_wdata, 64'hA);
    chk("st_a", alu_a, 64'hA);
    chk("st_req", 64'(imem_req), 0);
    imem_ack  = 1'b1;
    imem_data = enc(OP_HALT, 0, 0, 0, 0);
    @(negedge clock);
    imem_ack  = 1'b0;
    imem_data = '0;
    chk("st_we2", 64'(dmem_we), 1);
    chk("st_pc_hold", 64'(pc), 64'h42);
    @(negedge clock);
    chk("st_we3", 64'(dmem_we), 1);
    chk("st_data3", dmem_wdata, 64'hA);
    dmem_ack = 1'b1;
    @(negedge clock);
    dmem_ack = 1'b0;
    chk("st_we_off", 64'(dmem_we), 0);
    chk("st_pc", 64'(pc), 64'h43);
    chk("st_req_back", 64'(imem_req), 1);
    chk("st_not_halt", 64'(halted), 0);

    issue(enc(OP_DIV, 5, 6, 0, 0), 64'hDEAD, 0, 0, 0, n);
    chk("div0_b", alu_b, 0);
    chk("div0_err", 64'(err), 1);
    chk("div0_pc", 64'(pc), 64'h44);

    issue(enc(OP_MOV, 10, 0, 0, 20), 64'd20, 0, 0, 0, n);
    issue(enc(OP_MOV, 11, 0, 0, 4), 64'd4, 0, 0, 0, n);
    issue(enc(OP_DIV, 10, 11, 0, 0), 64'd5, 0, 0, 0, n);
    chk("div_a", alu_a, 64'd20);
    chk("div_b", alu_b, 64'd4);
    chk("div_err_sticky", 64'(err), 1);
    chk("div_pc", 64'(pc), 64'h47);

    issue(enc(OP_MOV, 10, 5, 0, 0), 0, 0, 0, 0, n);
    chk("div_result", alu_a, 64'd5);
    chk("div0_result", alu_b, 0);

    issue(enc(OP_EQ, 0, 0, 0, 0), 0, 1, 0, 0, n);
    issue(enc(OP_JMP, 0, 0, 0, 0), 0, 0, 1, 64'hFFFF, n);
    chk("jmp_f1", 64'(alu_f1), 1);
    chk("jmp_pc", 64'(pc), 64'hFFFF);
    chk("jmp_iaddr", 64'(imem_addr), 64'hFFFF);

    issue(enc(OP_ADD, 0, 0, 0, 0), 64'hA, 0, 0, 0, n);
    chk("wrap_pc", 64'(pc), 0);

    issue(enc(OP_HALT, 0, 0, 0, 0), 0, 0, 0, 0, n);
    chk("halt_cyc", 64'(n), 2);
    chk("halt_flag", 64'(halted), 1);
    hreq = 0;
    repeat (20) begin
      @(negedge clock);
      if (imem_req) hreq++;
    end
    chk("halt_req_quiet", 64'(hreq), 0);
    chk("halt_pc", 64'(pc), 0);
    chk("halt_sticky", 64'(halted), 1);

    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("unhalt_req", 64'(imem_req), 1);
    chk("unhalt_err", 64'(err), 0);

    issue(enc(OP_MOV, 10, 1, 0, 0), 0, 0, 0, 0, n);
    chk("rf_clr_a", alu_a, 0);
    chk("rf_clr_b", alu_b, 0);
    chk("rf_clr_pc", 64'(pc), 1);
    @(negedge clock);
    chk("wait_req", 64'(imem_req), 1);
    chk("wait_addr", 64'(imem_addr), 1);
    reset = 1'b1;
    @(negedge clock);
    chk("mid_req", 64'(imem_req), 0);
    chk("mid_pc", 64'(pc), 0);
    chk("mid_instr", 64'(alu_instr), 0);
    chk("mid_value", 64'(alu_value), 0);
    chk("mid_we", 64'(dmem_we), 0);
    chk("mid_halted", 64'(halted), 0);
    reset = 1'b0;
    @(negedge clock);
    chk("refetch_req", 64'(imem_req), 1);
    chk("refetch_addr", 64'(imem_addr), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
